// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the instruction port, data port and unified-memory signals.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_stall;

  logic                  m_en;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one fixed-latency
// single-port memory; data port wins unless fetch has been starved STARVE_MAX times.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t                state_reg, state_next;
  logic [3:0]            starve_cnt_reg, starve_cnt_next;
  logic [3:0]            lat_cnt_reg, lat_cnt_next;
  logic                  owner_reg, owner_next;  // 1 = data port
  logic                  m_en_reg, m_en_next;
  logic                  m_we_reg, m_we_next;
  logic [ADDR_WIDTH-1:0] m_addr_reg, m_addr_next;
  logic [DATA_WIDTH-1:0] m_wdata_reg, m_wdata_next;
  logic                  i_ack_reg, i_ack_next;
  logic                  d_ack_reg, d_ack_next;
  logic [DATA_WIDTH-1:0] i_rdata_reg, i_rdata_next;
  logic [DATA_WIDTH-1:0] d_rdata_reg, d_rdata_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      lat_cnt_reg    <= '0;
      owner_reg      <= 1'b0;
      m_en_reg       <= 1'b0;
      m_we_reg       <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      i_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      lat_cnt_reg    <= lat_cnt_next;
      owner_reg      <= owner_next;
      m_en_reg       <= m_en_next;
      m_we_reg       <= m_we_next;
      m_addr_reg     <= m_addr_next;
      m_wdata_reg    <= m_wdata_next;
      i_ack_reg      <= i_ack_next;
      d_ack_reg      <= d_ack_next;
      i_rdata_reg    <= i_rdata_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    lat_cnt_next    = lat_cnt_reg;
    owner_next      = owner_reg;
    m_en_next       = 1'b0;
    m_we_next       = m_we_reg;
    m_addr_next     = m_addr_reg;
    m_wdata_next    = m_wdata_reg;
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && starve_cnt_reg == STARVE_LIM)) begin
          owner_next   = 1'b1;
          m_en_next    = 1'b1;
          m_we_next    = bus.d_we;
          m_addr_next  = bus.d_addr;
          m_wdata_next = bus.d_wdata;
          lat_cnt_next = LAT_INIT;
          state_next   = WAIT;
          // Only consecutive D wins over a waiting fetch count toward starvation.
          if (!bus.i_req)
            starve_cnt_next = '0;
          else if (starve_cnt_reg != STARVE_LIM)
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end else if (bus.i_req) begin
          owner_next      = 1'b0;
          m_en_next       = 1'b1;
          m_we_next       = 1'b0;
          m_addr_next     = bus.i_addr;
          m_wdata_next    = '0;
          lat_cnt_next    = LAT_INIT;
          state_next      = WAIT;
          starve_cnt_next = '0;
        end
      end

      WAIT: begin
        if (lat_cnt_reg == '0) begin
          if (!m_we_reg) begin
            if (owner_reg) d_rdata_next = bus.m_rdata;
            else           i_rdata_next = bus.m_rdata;
          end
          // A requester that dropped its request has been flushed: no ack.
          if (owner_reg) d_ack_next = bus.d_req;
          else           i_ack_next = bus.i_req;
          state_next = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg - 4'd1;
        end
      end

      RESP: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign bus.m_en    = m_en_reg;
  assign bus.m_we    = m_we_reg;
  assign bus.m_addr  = m_addr_reg;
  assign bus.m_wdata = m_wdata_reg;
  assign bus.i_ack   = i_ack_reg;
  assign bus.d_ack   = d_ack_reg;
  assign bus.i_rdata = i_rdata_reg;
  assign bus.d_rdata = d_rdata_reg;
  assign bus.i_stall = bus.i_req & ~i_ack_reg;
  assign bus.d_stall = bus.d_req & ~d_ack_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a fixed-latency memory model;
// expected memory strobes and acks are queued by stimulus and checked by a monitor.
module tb_unified_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 4;
  localparam logic [DW-1:0] POISON = 32'hBAD0BAD0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  unified_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid exactly MEM_LAT cycles after the m_en cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [1:MEM_LAT];
  bit mem_init_done = 1'b0;

  function automatic logic [DW-1:0] init_val(int a);
    case (a)
      3:       return 32'h11112222;
      7:       return 32'h77770007;
      10:      return 32'h00A00093;
      12:      return 32'hC0FFEE12;
      20:      return 32'h20202020;
      default: return 32'hA5000000 | 32'(a);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] <= init_val(a);
      mem_init_done <= 1'b1;
    end else if (bus.m_en && bus.m_we) begin
      mem[bus.m_addr] <= bus.m_wdata;
    end
    rd_pipe[1] <= (bus.m_en && !bus.m_we) ? mem[bus.m_addr] : POISON;
    for (int k = 2; k <= MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.m_rdata = rd_pipe[MEM_LAT];

  typedef struct {
    bit            is_d;
    int            cyc;
    bit            chk_i;
    logic [DW-1:0] i_rd;
    bit            chk_d;
    logic [DW-1:0] d_rd;
  } ack_exp_t;

  typedef struct {
    int            cyc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  ack_exp_t ack_q[$];
  mem_exp_t mem_q[$];
  ack_exp_t ea;
  mem_exp_t em;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ack_exp_t mk_ack(bit is_d, int c, bit ci, logic [DW-1:0] ir,
                                      bit cd, logic [DW-1:0] dr);
    ack_exp_t e;
    e.is_d = is_d; e.cyc = c; e.chk_i = ci; e.i_rd = ir; e.chk_d = cd; e.d_rd = dr;
    return e;
  endfunction

  function automatic mem_exp_t mk_mem(int c, bit we, logic [AW-1:0] a, logic [DW-1:0] wd);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
    return e;
  endfunction

  // Monitor: every strobe and ack the DUT presents must match the next queued entry.
  always @(negedge clk) begin
    if (!reset) begin
      check("i_stall", 64'(bus.i_stall), 64'(bus.i_req & ~bus.i_ack));
      check("d_stall", 64'(bus.d_stall), 64'(bus.d_req & ~bus.d_ack));
      if (bus.m_en) begin
        check("m_en expected", 64'(mem_q.size() != 0), 64'(1));
        if (mem_q.size() != 0) begin
          em = mem_q.pop_front();
          check("m_en cycle", 64'(cyc), 64'(em.cyc));
          check("m_we", 64'(bus.m_we), 64'(em.we));
          check("m_addr", 64'(bus.m_addr), 64'(em.addr));
          if (em.we) check("m_wdata", 64'(bus.m_wdata), 64'(em.wdata));
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        check("ack expected", 64'(ack_q.size() != 0), 64'(1));
        if (ack_q.size() != 0) begin
          ea = ack_q.pop_front();
          check("d_ack", 64'(bus.d_ack), 64'(ea.is_d));
          check("i_ack", 64'(bus.i_ack), 64'(!ea.is_d));
          check("ack cycle", 64'(cyc), 64'(ea.cyc));
          if (ea.chk_i) check("i_rdata", 64'(bus.i_rdata), 64'(ea.i_rd));
          if (ea.chk_d) check("d_rdata", 64'(bus.d_rdata), 64'(ea.d_rd));
        end
      end
    end
  end

  task automatic wait_ack(bit is_d, int budget, string name);
    int n = 0;
    bit seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      seen = is_d ? bus.d_ack : bus.i_ack;
      n++;
    end
    check({name, " ack seen"}, 64'(seen), 64'(1));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    next_cycle();
  endtask

  task automatic drain(string name);
    repeat (4) next_cycle();
    check({name, " queues drained"}, 64'(ack_q.size() + mem_q.size()), 64'(0));
  endtask

  task automatic check_outputs_zero(string name);
    check({name, " m_en"}, 64'(bus.m_en), 64'(0));
    check({name, " m_we"}, 64'(bus.m_we), 64'(0));
    check({name, " m_addr"}, 64'(bus.m_addr), 64'(0));
    check({name, " m_wdata"}, 64'(bus.m_wdata), 64'(0));
    check({name, " i_ack"}, 64'(bus.i_ack), 64'(0));
    check({name, " d_ack"}, 64'(bus.d_ack), 64'(0));
    check({name, " i_rdata"}, 64'(bus.i_rdata), 64'(0));
    check({name, " d_rdata"}, 64'(bus.d_rdata), 64'(0));
  endtask

  int t0, t1;

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    check("reset i_stall", 64'(bus.i_stall), 64'(0));
    check("reset d_stall", 64'(bus.d_stall), 64'(0));
    reset = 1'b0;
    next_cycle();

    // Single fetch: m_en at +1, ack with data at +4.
    t0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 10'd10;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd10, '0));
    ack_q.push_back(mk_ack(1'b0, t0 + 4, 1'b1, 32'h00A00093, 1'b1, 32'h0));
    wait_ack(1'b0, 10, "single fetch");
    next_cycle();
    bus.i_req = 1'b0;
    drain("single fetch");

    // Load 7, store 5, load 5: d_rdata must survive the store ack.
    do_reset();
    t0 = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd7;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd7, '0));
    ack_q.push_back(mk_ack(1'b1, t0 + 4, 1'b1, 32'h0, 1'b1, 32'h77770007));
    wait_ack(1'b1, 10, "load 7");
    next_cycle();
    t0 = cyc;
    bus.d_we = 1'b1; bus.d_addr = 10'd5; bus.d_wdata = 32'hDEADBEEF;
    mem_q.push_back(mk_mem(t0 + 1, 1'b1, 10'd5, 32'hDEADBEEF));
    ack_q.push_back(mk_ack(1'b1, t0 + 4, 1'b1, 32'h0, 1'b1, 32'h77770007));
    wait_ack(1'b1, 10, "store 5");
    next_cycle();
    t0 = cyc;
    bus.d_we = 1'b0; bus.d_wdata = 32'h0;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd5, '0));
    ack_q.push_back(mk_ack(1'b1, t0 + 4, 1'b1, 32'h0, 1'b1, 32'hDEADBEEF));
    wait_ack(1'b1, 10, "load 5");
    next_cycle();
    bus.d_req = 1'b0;
    drain("store/load");

    // Simultaneous requests: D first (ack +4), then I (m_en +6, ack +9).
    do_reset();
    t0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 10'd20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd7;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd7, '0));
    mem_q.push_back(mk_mem(t0 + 6, 1'b0, 10'd20, '0));
    ack_q.push_back(mk_ack(1'b1, t0 + 4, 1'b1, 32'h0, 1'b1, 32'h77770007));
    ack_q.push_back(mk_ack(1'b0, t0 + 9, 1'b1, 32'h20202020, 1'b1, 32'h77770007));
    fork
      begin wait_ack(1'b1, 12, "simul D"); next_cycle(); bus.d_req = 1'b0; end
      begin wait_ack(1'b0, 16, "simul I"); next_cycle(); bus.i_req = 1'b0; end
    join
    drain("simultaneous");

    // Starvation: both held; four D grants, one forced I, then D again.
    do_reset();
    t0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 10'd20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd7;
    for (int k = 0; k < 4; k++) begin
      mem_q.push_back(mk_mem(t0 + 1 + 5*k, 1'b0, 10'd7, '0));
      ack_q.push_back(mk_ack(1'b1, t0 + 4 + 5*k, 1'b1, 32'h0, 1'b1, 32'h77770007));
    end
    mem_q.push_back(mk_mem(t0 + 21, 1'b0, 10'd20, '0));
    ack_q.push_back(mk_ack(1'b0, t0 + 24, 1'b1, 32'h20202020, 1'b1, 32'h77770007));
    mem_q.push_back(mk_mem(t0 + 26, 1'b0, 10'd7, '0));
    ack_q.push_back(mk_ack(1'b1, t0 + 29, 1'b1, 32'h20202020, 1'b1, 32'h77770007));
    fork
      begin
        for (int k = 0; k < 5; k++) wait_ack(1'b1, 40, "starve D");
        next_cycle();
        bus.d_req = 1'b0;
      end
      begin wait_ack(1'b0, 40, "starve I"); next_cycle(); bus.i_req = 1'b0; end
    join
    drain("starvation");

    // Abort: fetch of 3 dropped in WAIT; D request at +5 served from IDLE.
    do_reset();
    t0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 10'd3;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd3, '0));
    repeat (2) next_cycle();
    bus.i_req = 1'b0;
    repeat (3) next_cycle();
    t1 = cyc;
    check("abort D start cycle", 64'(t1 - t0), 64'(5));
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd10;
    mem_q.push_back(mk_mem(t1 + 1, 1'b0, 10'd10, '0));
    ack_q.push_back(mk_ack(1'b1, t1 + 4, 1'b0, 32'h0, 1'b1, 32'h00A00093));
    wait_ack(1'b1, 10, "after abort");
    next_cycle();
    bus.d_req = 1'b0;
    drain("abort");

    // Reset during a load's WAIT: outputs clear at once, no late ack.
    do_reset();
    t0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 10'd10;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd10, '0));
    ack_q.push_back(mk_ack(1'b0, t0 + 4, 1'b1, 32'h00A00093, 1'b1, 32'h0));
    wait_ack(1'b0, 10, "pre-reset fetch");
    next_cycle();
    bus.i_req = 1'b0;
    t0 = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd7;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd7, '0));
    ack_q.push_back(mk_ack(1'b1, t0 + 4, 1'b1, 32'h00A00093, 1'b1, 32'h77770007));
    wait_ack(1'b1, 10, "pre-reset load");
    next_cycle();
    t1 = cyc;
    bus.d_addr = 10'd12;
    mem_q.push_back(mk_mem(t1 + 1, 1'b0, 10'd12, '0));
    repeat (2) next_cycle();
    reset = 1'b1;
    bus.d_req = 1'b0;
    #1 check_outputs_zero("mid-wait reset");
    repeat (2) next_cycle();
    reset = 1'b0;
    repeat (8) next_cycle();
    check("no ack after reset", 64'(ack_q.size() + mem_q.size()), 64'(0));
    t0 = cyc;
    bus.d_req = 1'b1; bus.d_addr = 10'd12;
    mem_q.push_back(mk_mem(t0 + 1, 1'b0, 10'd12, '0));
    ack_q.push_back(mk_ack(1'b1, t0 + 4, 1'b1, 32'h0, 1'b1, 32'hC0FFEE12));
    wait_ack(1'b1, 10, "post-reset load");
    next_cycle();
    bus.d_req = 1'b0;
    drain("reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
